// File: rtl/classifier_pkg.sv
// Shared types and helpers for the classifier energy-check block.
package classifier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Accumulator width that cannot overflow with every bin at full scale.
  function automatic int calc_acc_w(input int bit_width, input int n_samples);
    return bit_width + $clog2(n_samples);
  endfunction

endpackage

// File: rtl/classifier_energy_check_dpath.sv
// Datapath: frame latches, bin index, masked-energy accumulator and threshold compare.
// CLASSIFIER_ENERGY_BIN_COUNT_EN adds a masked-bin counter output.
module classifier_energy_check_dpath
  import classifier_pkg::*;
#(
  parameter int  BIT_WIDTH = 32,
  parameter int  N_SAMPLES = 8,
  localparam int ACC_W     = calc_acc_w(BIT_WIDTH, N_SAMPLES),
  localparam int IDX_W     = $clog2(N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] mag_i [N_SAMPLES],
  input  logic                 mask_i [N_SAMPLES],
  input  logic [ACC_W-1:0]     threshold_i,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic                 last_bin_o,
  output logic [ACC_W-1:0]     energy_o,
  output logic                 above_o
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
  ,
  output logic [$clog2(N_SAMPLES+1)-1:0] count_o
`endif
);

  logic [BIT_WIDTH-1:0] mag_q [N_SAMPLES];
  logic                 mask_q [N_SAMPLES];
  logic [ACC_W-1:0]     thr_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 last_bin;
  logic [ACC_W-1:0]     addend;

  // NOTE: the frame latches hold pure data that is always written on accept
  // before being read, so they carry no reset and map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (load_i) begin
      mag_q  <= mag_i;
      mask_q <= mask_i;
    end
  end

  assign last_bin = (idx_q == IDX_W'(N_SAMPLES - 1));

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    addend = '0;
    idx_d  = idx_q;
    acc_d  = acc_q;
    if (mask_q[idx_q]) addend = ACC_W'(mag_q[idx_q]);
    if (load_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (step_i) begin
      idx_d = last_bin ? '0 : idx_q + IDX_W'(1);
      acc_d = acc_q + addend;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      if (load_i) thr_q <= threshold_i;
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + CNT_W'(mask_q[idx_q]);
    end
  end

  assign count_o = cnt_q;
`endif

  assign last_bin_o = last_bin;
  assign energy_o   = acc_q;
  // Strict unsigned compare: a total equal to the threshold does not classify.
  assign above_o    = (acc_q > thr_q);

endmodule

// File: rtl/classifier_energy_check.sv
// Masked-bin energy classifier: FSM and val/rdy handshake around the datapath.
// CLASSIFIER_ENERGY_BIN_COUNT_EN adds the send_count output.
module classifier_energy_check
  import classifier_pkg::*;
#(
  parameter int  BIT_WIDTH = 32,
  parameter int  N_SAMPLES = 8,
  localparam int ACC_W     = calc_acc_w(BIT_WIDTH, N_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] recv_mag [N_SAMPLES],
  input  logic                 recv_mask [N_SAMPLES],
  input  logic [ACC_W-1:0]     recv_threshold,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic                 send_msg,
  output logic [ACC_W-1:0]     send_energy,
  output logic                 send_val,
  input  logic                 send_rdy
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
  ,
  output logic [$clog2(N_SAMPLES+1)-1:0] send_count
`endif
);

  state_e state_q, state_d;
  logic   load;
  logic   step;
  logic   last_bin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // recv_rdy is gated by reset_n so it reads 0 for the whole reset window.
  always_comb begin
    state_d  = state_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        recv_rdy = reset_n;
        if (recv_val && reset_n) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_bin) state_d = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load = recv_rdy && recv_val;
  assign step = (state_q == ACCUM);

  classifier_energy_check_dpath #(
    .BIT_WIDTH(BIT_WIDTH),
    .N_SAMPLES(N_SAMPLES)
  ) u_dpath (
    .clk        (clk),
    .reset_n    (reset_n),
    .mag_i      (recv_mag),
    .mask_i     (recv_mask),
    .threshold_i(recv_threshold),
    .load_i     (load),
    .step_i     (step),
    .last_bin_o (last_bin),
    .energy_o   (send_energy),
    .above_o    (send_msg)
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
    ,
    .count_o    (send_count)
`endif
  );

endmodule

// File: tb/tb_classifier_energy_check.sv
// Scoreboard bench: the driver queues expected results at accept, a negedge monitor compares them.
module tb_classifier_energy_check;
  import classifier_pkg::*;

  localparam int BW    = 32;
  localparam int N     = 8;
  localparam int ACC_W = calc_acc_w(BW, N);

  typedef logic [BW-1:0] mag_arr_t [N];
  typedef logic          mask_arr_t [N];

  typedef struct {
    logic [ACC_W-1:0] energy;
    logic             msg;
    int               count;
    int               acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  mag_arr_t         recv_mag;
  mask_arr_t        recv_mask;
  logic [ACC_W-1:0] recv_threshold;
  logic             recv_val;
  logic             recv_rdy;
  logic             send_msg;
  logic [ACC_W-1:0] send_energy;
  logic             send_val;
  logic             send_rdy;
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
  logic [$clog2(N+1)-1:0] send_count;
`endif

  classifier_energy_check #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .recv_mag      (recv_mag),
    .recv_mask     (recv_mask),
    .recv_threshold(recv_threshold),
    .recv_val      (recv_val),
    .recv_rdy      (recv_rdy),
    .send_msg      (send_msg),
    .send_energy   (send_energy),
    .send_val      (send_val),
    .send_rdy      (send_rdy)
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
    ,
    .send_count    (send_count)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  int   rise_cyc = 0;
  logic prev_val = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares each completed send handshake against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && send_val && !prev_val) rise_cyc = cyc;
      prev_val = reset_n && send_val;
      if (reset_n && send_val && send_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("energy", 64'(send_energy), 64'(e.energy));
          check("msg", 64'(send_msg), 64'(e.msg));
          check("latency", 64'(rise_cyc - e.acc_cyc), 64'(N));
`ifdef CLASSIFIER_ENERGY_BIN_COUNT_EN
          check("count", 64'(send_count), 64'(e.count));
`endif
        end
      end
    end
  end

  // Driver tasks are entered and left at posedge+#1.
  task automatic accept_frame(input mag_arr_t m, input mask_arr_t k, input logic [ACC_W-1:0] thr,
                              input logic [ACC_W-1:0] e_energy, input logic e_msg, input int e_count);
    int w = 0;
    recv_mag       = m;
    recv_mask      = k;
    recv_threshold = thr;
    recv_val       = 1'b1;
    while (!recv_rdy && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!recv_rdy) begin
      check("accept_timeout", 64'd0, 64'd1);
      recv_val = 1'b0;
      return;
    end
    @(posedge clk); #1;
    recv_val = 1'b0;
    exp_q.push_back('{energy: e_energy, msg: e_msg, count: e_count, acc_cyc: cyc});
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mag_arr_t  m_ramp, m_max, m_five, m_tens, m_three, m_scr;
    mask_arr_t k_odd, k_all, k_none, k_low, k_scr;
    int w;

    m_ramp  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    m_tens  = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    k_odd   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    k_low   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < N; i++) begin
      m_max[i]   = 32'hFFFF_FFFF;
      m_five[i]  = 32'd5;
      m_three[i] = 32'd3;
      k_all[i]   = 1'b1;
      k_none[i]  = 1'b0;
    end

    reset_n = 1'b0; recv_val = 1'b0; send_rdy = 1'b1;
    recv_mag = m_ramp; recv_mask = k_none; recv_threshold = '0;

    // Reset state and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_recv_rdy", 64'(recv_rdy), 64'd0);
    check("rst_send_val", 64'(send_val), 64'd0);
    check("rst_energy", 64'(send_energy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_recv_rdy", 64'(recv_rdy), 64'd1);
    check("post_rst_send_val", 64'(send_val), 64'd0);
    check("post_rst_energy", 64'(send_energy), 64'd0);
    check("post_rst_msg", 64'(send_msg), 64'd0);

    // Odd bins 2+4+6+8 = 20, strict compare around the threshold.
    accept_frame(m_ramp, k_odd, 35'd19, 35'd20, 1'b1, 4); wait_drain();
    accept_frame(m_ramp, k_odd, 35'd20, 35'd20, 1'b0, 4); wait_drain();

    // Full scale: 8 * (2^32-1) = 0x7_FFFF_FFF8, no overflow.
    accept_frame(m_max, k_all, 35'd0, 35'h7_FFFF_FFF8, 1'b1, 8); wait_drain();
    accept_frame(m_max, k_none, 35'd0, 35'd0, 1'b0, 0); wait_drain();

    // Backpressure: bins 0..3 of 5 = 20, held 5 cycles with a competing frame offered.
    send_rdy = 1'b0;
    accept_frame(m_five, k_low, 35'd100, 35'd20, 1'b0, 4);
    w = 0;
    while (!send_val && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("bp_send_val_rise", 64'(send_val), 64'd1);
    recv_mag = m_ramp; recv_mask = k_all; recv_threshold = '0; recv_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_val", 64'(send_val), 64'd1);
      check("bp_recv_rdy", 64'(recv_rdy), 64'd0);
      check("bp_hold_energy", 64'(send_energy), 64'd20);
      check("bp_hold_msg", 64'(send_msg), 64'd0);
      @(posedge clk); #1;
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_recv_rdy", 64'(recv_rdy), 64'd1);
    check("bp_idle_send_val", 64'(send_val), 64'd0);
    check("bp_idle_energy_hold", 64'(send_energy), 64'd20);

    // Inputs scrambled during ACCUM: 10+..+80 = 360 from the latched frame.
    accept_frame(m_tens, k_all, 35'd359, 35'd360, 1'b1, 8);
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) begin
        m_scr[i] = $urandom;
        k_scr[i] = 1'($urandom_range(0, 1));
      end
      recv_mag = m_scr; recv_mask = k_scr; recv_threshold = 35'($urandom);
      @(posedge clk); #1;
    end
    wait_drain();

    // Reset in ACCUM cycle 4 aborts the frame with no output.
    recv_mag = m_five; recv_mask = k_all; recv_threshold = '0; recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_send_val", 64'(send_val), 64'd0);
    check("abort_recv_rdy", 64'(recv_rdy), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_recv_rdy", 64'(recv_rdy), 64'd1);
    check("abort_energy_cleared", 64'(send_energy), 64'd0);
    repeat (N + 2) @(posedge clk);
    #1;
    check("abort_no_output", 64'(send_val), 64'd0);

    accept_frame(m_three, k_all, 35'd23, 35'd24, 1'b1, 8); wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
